// File: rtl/drum_audio_pkg.sv
// Shared types and constants for the audio output path: FSM encoding, rates, sample width.
// Latency: none (declarations and a combinational saturating-shift helper only).
// Backpressure: not applicable.
package drum_audio_pkg;

   localparam int SAMPLE_W      = 32;
   localparam int DEF_CLK_HZ    = 50_000_000;
   localparam int DEF_SAMPLE_HZ = 48_000;

   // Three guard bits cover the largest left shift (gain = 3).
   localparam int SAT_W = SAMPLE_W + 3;

   typedef logic signed [SAMPLE_W-1:0] sample_t;

   typedef enum logic [1:0] {
      S_WAIT  = 2'd0,
      S_PEND  = 2'd1,
      S_WRITE = 2'd2
   } wr_state_t;

   localparam sample_t SAT_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
   localparam sample_t SAT_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

   localparam logic signed [SAT_W-1:0] WIDE_HI = {4'b0000, {(SAMPLE_W-1){1'b1}}};
   localparam logic signed [SAT_W-1:0] WIDE_LO = {4'b1111, {(SAMPLE_W-1){1'b0}}};

   // Arithmetic left shift by 0..3 with clamping to the signed sample range.
   function automatic sample_t sat_shift(input sample_t s, input logic [1:0] sh);
      logic signed [SAT_W-1:0] wide;
      wide = {{3{s[SAMPLE_W-1]}}, s};
      wide = wide <<< sh;
      if (wide > WIDE_HI) begin
         return SAT_MAX;
      end else if (wide < WIDE_LO) begin
         return SAT_MIN;
      end
      return wide[SAMPLE_W-1:0];
   endfunction

endpackage

// File: rtl/audio_stream_writer_if.sv
// Codec write-port bundle: sample pair, write strobe and the codec's space indication.
// Latency: none (wires only).
// Backpressure: audio_out_allowed low holds the writer's sample pending.
interface audio_stream_writer_if;
   import drum_audio_pkg::*;

   logic                audio_out_allowed;
   logic [SAMPLE_W-1:0] left_out;
   logic [SAMPLE_W-1:0] right_out;
   logic                write_audio_out;

   // Writer side drives samples and strobe.
   modport master (
      input  audio_out_allowed,
      output left_out,
      output right_out,
      output write_audio_out
   );

   // Codec side reports space and consumes samples.
   modport slave (
      output audio_out_allowed,
      input  left_out,
      input  right_out,
      input  write_audio_out
   );

endinterface

// File: rtl/rate_tick_gen.sv
// Phase accumulator producing an exact-average SAMPLE_HZ strobe from a CLK_HZ clock.
// Latency: registered strobe, one cycle after the accumulator wraps.
// Backpressure: none; free-running regardless of downstream state.
module rate_tick_gen
   import drum_audio_pkg::*;
#(
   parameter int CLK_HZ    = DEF_CLK_HZ,
   parameter int SAMPLE_HZ = DEF_SAMPLE_HZ
) (
   input  logic clk,
   input  logic reset,
   output logic sample_tick
);

   localparam logic [32:0] STEP = 33'(SAMPLE_HZ);
   localparam logic [32:0] WRAP = 33'(CLK_HZ);

   logic [31:0] acc;
   logic [32:0] acc_sum;

   // One extra bit so the sum cannot overflow before the wrap compare.
   assign acc_sum = {1'b0, acc} + STEP;

   // Advance the phase; subtract a full period on wrap and flag the tick.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc         <= '0;
         sample_tick <= 1'b0;
      end else if (acc_sum >= WRAP) begin
         acc         <= 32'(acc_sum - WRAP);
         sample_tick <= 1'b1;
      end else begin
         acc         <= acc_sum[31:0];
         sample_tick <= 1'b0;
      end
   end

endmodule

// File: rtl/audio_stream_writer.sv
// Sample-rate output stage: captures mix_down per tick, applies gain/fade, writes codec. Optional macro AUDIO_FADE_EN.
// Latency: tick in cycle t -> sample held at t+1 edge -> write strobe in t+2 when codec allows.
// Backpressure: while audio_out_allowed is low the sample waits; a newer tick overwrites it and counts a drop.
module audio_stream_writer
   import drum_audio_pkg::*;
#(
   parameter int CLK_HZ    = DEF_CLK_HZ,
   parameter int SAMPLE_HZ = DEF_SAMPLE_HZ,
   parameter int FADE_BITS = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic [SAMPLE_W-1:0]  mix_down,
   input  logic [1:0]           gain,
   audio_stream_writer_if.master codec,
   output logic                 sample_tick,
   output logic [15:0]          drop_count
);

   wr_state_t state, state_nxt;
   sample_t   hold, hold_nxt;
   sample_t   src;
   sample_t   g;
   logic      drop_inc;
   logic      wr_r;

   rate_tick_gen #(
      .CLK_HZ    (CLK_HZ),
      .SAMPLE_HZ (SAMPLE_HZ)
   ) u_rate (
      .clk         (clk),
      .reset       (reset),
      .sample_tick (sample_tick)
   );

`ifdef AUDIO_FADE_EN
   localparam int               LVL_W   = FADE_BITS + 1;
   localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(2 ** FADE_BITS);

   logic [LVL_W-1:0]   lvl, lvl_nxt;
   logic signed [47:0] mix_wide;
   logic signed [47:0] lvl_wide;
   logic signed [47:0] fade_prod;

   // Ramp toward full scale while playing and toward silence while stopped.
   always_comb begin
      lvl_nxt = lvl;
      if (en && (lvl != LVL_MAX)) begin
         lvl_nxt = lvl + 1'b1;
      end else if (!en && (lvl != '0)) begin
         lvl_nxt = lvl - 1'b1;
      end
   end

   // Level steps once per sample period.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lvl <= '0;
      end else if (sample_tick) begin
         lvl <= lvl_nxt;
      end
   end

   // The sample being captured uses the level it ramps to on this tick,
   // so the first sample after play already carries one step.
   assign mix_wide  = {{16{mix_down[SAMPLE_W-1]}}, mix_down};
   assign lvl_wide  = 48'(lvl_nxt);
   assign fade_prod = mix_wide * lvl_wide;
   assign src       = fade_prod[FADE_BITS +: SAMPLE_W];
`else
   // Hard mute: stopped play substitutes silence immediately.
   assign src = en ? sample_t'(mix_down) : '0;
`endif

   assign g = sat_shift(src, gain);

   // Next-state: capture on tick, overwrite (and count) a sample still pending.
   always_comb begin
      state_nxt = state;
      hold_nxt  = hold;
      drop_inc  = 1'b0;
      unique case (state)
         S_WAIT: begin
            if (sample_tick) begin
               hold_nxt  = g;
               state_nxt = S_PEND;
            end
         end
         S_PEND: begin
            if (sample_tick) begin
               hold_nxt  = g;
               drop_inc  = 1'b1;
               state_nxt = codec.audio_out_allowed ? S_WRITE : S_PEND;
            end else if (codec.audio_out_allowed) begin
               state_nxt = S_WRITE;
            end
         end
         S_WRITE: begin
            if (sample_tick) begin
               hold_nxt  = g;
               state_nxt = S_PEND;
            end else begin
               state_nxt = S_WAIT;
            end
         end
         default: begin
            state_nxt = S_WAIT;
         end
      endcase
   end

   // State, held sample, write strobe and saturating drop counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_WAIT;
         hold       <= '0;
         wr_r       <= 1'b0;
         drop_count <= '0;
      end else begin
         state <= state_nxt;
         hold  <= hold_nxt;
         wr_r  <= (state_nxt == S_WRITE);
         if (drop_inc && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
         end
      end
   end

   // hold only changes when leaving S_WRITE, so the pair is stable for the strobe.
   assign codec.left_out        = hold;
   assign codec.right_out       = hold;
   assign codec.write_audio_out = wr_r;

endmodule

// File: tb/tb_audio_stream_writer.sv
// Scoreboard bench for audio_stream_writer: directed stimulus pushes expected writes, a monitor pops them.
// Latency: checks the first tick position, tick spacing and the tick-to-write ordering.
// Backpressure: exercises drops, simultaneous tick/allow and reset while a sample is pending.
module tb_audio_stream_writer;
   import drum_audio_pkg::*;

`ifdef AUDIO_FADE_EN
   localparam int TB_FADE_BITS = 2;
`else
   localparam int TB_FADE_BITS = 8;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic [31:0] mix_down;
   logic [1:0]  gain;
   logic        sample_tick;
   logic [15:0] drop_count;

   audio_stream_writer_if bus();

   audio_stream_writer #(
      .CLK_HZ    (50_000_000),
      .SAMPLE_HZ (48_000),
      .FADE_BITS (TB_FADE_BITS)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .en          (en),
      .mix_down    (mix_down),
      .gain        (gain),
      .codec       (bus),
      .sample_tick (sample_tick),
      .drop_count  (drop_count)
   );

   always #5 clk = ~clk;

   int          checks      = 0;
   int          errors      = 0;
   int          writes_seen = 0;
   int          exp_writes  = 0;
   logic        prev_wr     = 1'b0;
   logic [31:0] exp_q[$];

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic expect_write(input logic [31:0] v);
      exp_q.push_back(v);
      exp_writes++;
   endtask

   // Returns at the negedge where sample_tick is high (before the capture edge).
   task automatic wait_tick(input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!sample_tick && n < 2000);
      if (!sample_tick) begin
         checks++;
         errors++;
         $display("FAIL %s: got no sample_tick in 2000 cycles, expected one", name);
      end
   endtask

   // Tick plus the capture edge, so inputs may change safely afterwards.
   task automatic next_sample(input string name);
      wait_tick(name);
      @(negedge clk);
   endtask

   // Monitor: every strobe must match the oldest expected sample; no back-to-back strobes.
   always @(negedge clk) begin
      logic [31:0] e;
      if (reset) begin
         prev_wr = 1'b0;
      end else begin
         if (bus.write_audio_out) begin
            writes_seen++;
            check32("write_gap", {31'b0, prev_wr}, 32'd0);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got write of 0x%08h, expected no write", bus.left_out);
            end else begin
               e = exp_q.pop_front();
               check32("left_out", bus.left_out, e);
               check32("right_out", bus.right_out, e);
            end
         end
         prev_wr = bus.write_audio_out;
      end
   end

   initial begin
      int ticks;
      int last;
      logic [31:0] fade_vals[5];

      reset                 = 1'b1;
      en                    = 1'b1;
      mix_down              = '0;
      gain                  = '0;
      bus.audio_out_allowed = 1'b1;
      repeat (3) @(negedge clk);
      check32("rst_left", bus.left_out, 32'h0);
      check32("rst_right", bus.right_out, 32'h0);
      check32("rst_write", {31'b0, bus.write_audio_out}, 32'd0);
      check32("rst_tick", {31'b0, sample_tick}, 32'd0);
      check32("rst_drop", {16'b0, drop_count}, 32'd0);
      reset = 1'b0;

      // Rate: 50,000 cycles at default rates give exactly 48 ticks.
      for (int i = 0; i < 48; i++) expect_write(32'h0);
      ticks = 0;
      last  = 0;
      for (int n = 1; n <= 50000; n++) begin
         @(negedge clk);
         if (sample_tick) begin
            ticks++;
            if (ticks == 1) begin
               check32("first_tick_cycle", n, 32'd1042);
            end else begin
               checks++;
               if (!((n - last == 1041) || (n - last == 1042))) begin
                  errors++;
                  $display("FAIL tick_spacing: got %0d cycles, expected 1041 or 1042", n - last);
               end
            end
            last = n;
         end
      end
      check32("tick_count", ticks, 32'd48);
      repeat (4) @(negedge clk);
      check32("rate_write_count", writes_seen, 32'd48);
      check32("rate_queue_empty", exp_q.size(), 32'd0);

      // Gain and saturation.
      mix_down = 32'h3000_0000; gain = 2'd2; expect_write(32'h7FFF_FFFF);
      next_sample("gain_pos_sat");
      mix_down = 32'hF000_0000; gain = 2'd2; expect_write(32'hC000_0000);
      next_sample("gain_neg");
      mix_down = 32'hC000_0000; gain = 2'd1; expect_write(32'h8000_0000);
      next_sample("gain_neg_edge");
      repeat (4) @(negedge clk);

      // Drops: three samples while the codec is full; only the last is written.
      bus.audio_out_allowed = 1'b0;
      gain = 2'd0;
      mix_down = 32'd1; next_sample("drop_1");
      mix_down = 32'd2; next_sample("drop_2");
      mix_down = 32'd3; next_sample("drop_3");
      check32("drop_pending_hold", bus.left_out, 32'd3);
      check32("drop_count_2", {16'b0, drop_count}, 32'd2);
      expect_write(32'd3);
      bus.audio_out_allowed = 1'b1;
      repeat (4) @(negedge clk);
      check32("drop_count_after", {16'b0, drop_count}, 32'd2);
      check32("drop_write_count", writes_seen, exp_writes);

      // Simultaneous tick and allow while pending: the newer sample wins.
      bus.audio_out_allowed = 1'b0;
      mix_down = 32'h55; next_sample("sim_first");
      mix_down = 32'h66; expect_write(32'h66);
      wait_tick("sim_second");
      bus.audio_out_allowed = 1'b1;
      @(negedge clk);
      check32("sim_strobe", {31'b0, bus.write_audio_out}, 32'd1);
      check32("sim_value", bus.left_out, 32'h66);
      check32("sim_drop", {16'b0, drop_count}, 32'd3);
      repeat (3) @(negedge clk);

`ifndef AUDIO_FADE_EN
      // Mute: stopped play keeps writing silence each period.
      en = 1'b0;
      mix_down = 32'h1234;
      for (int i = 0; i < 3; i++) begin
         expect_write(32'h0);
         next_sample("mute");
      end
      repeat (4) @(negedge clk);
      check32("mute_write_count", writes_seen, exp_writes);
      en = 1'b1;
`endif

      // Reset while a sample is pending discards it.
      bus.audio_out_allowed = 1'b0;
      mix_down = 32'h777;
      next_sample("rst_pend");
      check32("pend_before_rst", bus.left_out, 32'h777);
      reset = 1'b1;
      @(negedge clk);
      check32("midrst_left", bus.left_out, 32'h0);
      check32("midrst_right", bus.right_out, 32'h0);
      check32("midrst_write", {31'b0, bus.write_audio_out}, 32'd0);
      check32("midrst_drop", {16'b0, drop_count}, 32'd0);
      bus.audio_out_allowed = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      check32("midrst_no_write", writes_seen, exp_writes);

`ifdef AUDIO_FADE_EN
      // Fade-in from silence with a 4-step ramp.
      fade_vals = '{32'd100, 32'd200, 32'd300, 32'd400, 32'd400};
      en = 1'b1;
      mix_down = 32'd400;
      gain = 2'd0;
      for (int i = 0; i < 5; i++) begin
         expect_write(fade_vals[i]);
         next_sample("fade");
      end
      repeat (4) @(negedge clk);
`else
      fade_vals = '{default: 32'h0};
`endif

      repeat (4) @(negedge clk);
      check32("final_queue_empty", exp_q.size(), 32'd0);
      check32("final_write_count", writes_seen, exp_writes);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
